seq_mul_bcd_display: RTL and testbench
======================================

// Module: seq_mul_bcd_display
// PURPOSE
//  Parametrised sequential multiplier with decimal seven-segment readout; successor to the 4x4 combinational multiplier/BCD/SSD path.
//  Multiplies two WIDTH-bit unsigned operands by shift-add, then converts the product to BCD by iterative double-dabble.
//  Drives DIGITS seven-segment displays under a start/busy/done handshake.
//  Sits between the operand switches/registers and the board display pins.
// PARAMETERS
//  WIDTH   4  operand width in bits; product is 2*WIDTH bits.
//  DIGITS  3  number of decimal digits displayed; must hold (2^WIDTH-1)^2 (elaboration error otherwise).
// PORTS
//  clk       in   1           single clock; all state changes on rising edge.
//  rst       in   1           synchronous, active-high reset.
//  a         in   WIDTH       operand A, unsigned; sampled only on accepted start.
//  b         in   WIDTH       operand B, unsigned; sampled only on accepted start.
//  start     in   1           request; accepted only when busy=0 (state IDLE).
//  busy      out  1           high in MUL, BCD and DONE states.
//  done      out  1           one-cycle pulse; product and segments valid from this cycle.
//  product   out  2*WIDTH     registered binary product, held until the next done.
//  segOut    out  7*DIGITS    digit i at [7i+6:7i] (i=0 units); active-high, bit order {g,f,e,d,c,b,a}.
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, product=0, segOut=0 (all segments off). Applies from any state; an in-flight operation is discarded.
//  FSM: IDLE -(start)-> MUL -(WIDTH cycles)-> BCD -(2*WIDTH cycles)-> DONE -(1 cycle)-> IDLE.
//  IDLE: on start=1, load a, b; clear accumulator and BCD shift register. No other action.
//  MUL: one multiplier bit per cycle, LSB first; add shifted A when the bit is 1; accumulator is 2*WIDTH bits and never overflows.
//  BCD: per cycle, add 3 to each nibble >=5, then shift the next product bit in, MSB first; BCD register is 4*DIGITS bits.
//  DONE: done=1; product and segOut register the new result on entry to DONE, so they are valid in the done cycle.
//  Latency: done asserts exactly 3*WIDTH+1 cycles after the cycle start is sampled (13 at WIDTH=4).
//  Throughput: start during DONE is ignored; the earliest next accept is the cycle after done.
//  start while busy=1: ignored, no queuing; the operation in flight is unaffected.
//  a/b changes after accept: no effect on the result.
//  Outputs between operations: product and segOut hold the last result.
//  Zero operand: the full sequence still runs; latency is fixed and not data-dependent.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: leading zero digits above the most significant nonzero digit are driven 7'b0000000.
//    Units digit always shows, so a product of 0 displays a single "0".
//  LEADING_ZERO_BLANK_EN undefined: every digit shows its BCD value, with leading zeros drawn as "0".
// STRUCTURE
//  Shared package mul_bcd_pkg:
//    state encoding localparams (IDLE, MUL, BCD, DONE).
//    SEG_0..SEG_9 and SEG_BLANK constants.
//    BCD nibble width (4).
//  Sub-module seg7_decoder: 4-bit BCD in, 7-bit segments out, combinational.
//    Instantiated DIGITS times via generate; codes 10-15 give SEG_BLANK.
//  Top holds the FSM, cycle counter, shift-add datapath, double-dabble register and output registers.
// TESTING
//  T1: WIDTH=4, DIGITS=3, a=15, b=15, start 1 cycle -> done 13 cycles later, product=225, segOut={7'b1011011,7'b1011011,7'b1101101}.
//  T2: a=0, b=9 -> done after 13 cycles, product=0.
//      Without macro: all three digits 7'b0111111.
//      With LEADING_ZERO_BLANK_EN: units 7'b0111111, upper two digits 7'b0000000.
//  T3: accept a=3,b=4; pulse start=1 with a=15,b=15 at cycles 2 and 12 -> single done, product=12; no second done.
//  T4: accept a=7,b=7; assert rst at cycle 5 -> next cycle busy=0, done=0, product=0, segOut=0; no done follows.
//  T5: WIDTH=8, DIGITS=5, a=255, b=255 -> done 25 cycles after start, product=65025, digits 6,5,0,2,5.
//  T6: start held high continuously -> done every 14 cycles; each result matches the operands sampled at its own accept cycle.

Source files
------------

// File: rtl/mul_bcd_pkg.sv
// Shared constants for the sequential multiplier with BCD display.
// FSM state encoding, segment patterns and BCD nibble width.
package mul_bcd_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] BCD  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int BCD_W = 4;

    // Segment order {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to seven-segment pattern, purely combinational.
// Non-decimal codes 10-15 render as a blank digit.
module seg7_decoder
    import mul_bcd_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    // Map the digit value onto its segment pattern.
    always_comb begin
        seg = SEG_BLANK;
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seq_mul_bcd_display.sv
// Shift-add multiplier followed by double-dabble BCD conversion and 7-seg drive.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (units always shown).
module seq_mul_bcd_display
    import mul_bcd_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    product,
    output logic [7*DIGITS-1:0]   segOut
);

    localparam int PW = 2 * WIDTH;
    localparam int BW = BCD_W * DIGITS;
    localparam int CW = $clog2(PW);
    localparam longint unsigned OPMAX = (64'd1 << WIDTH) - 64'd1;

    if (OPMAX * OPMAX >= pow10(DIGITS)) begin : gBadDigits
        $error("DIGITS cannot hold the largest product");
    end

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    bReg;
    logic [PW-1:0]       aSh;
    logic [PW-1:0]       acc;
    logic [PW-1:0]       accNext;
    logic [PW-1:0]       prodSh;
    logic [BW-1:0]       bcdReg;
    logic [BW-1:0]       bcdAdj;
    logic [BW-1:0]       bcdNext;
    logic [7*DIGITS-1:0] segRaw;
    logic [7*DIGITS-1:0] segNext;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Accumulator after the current multiplier bit is consumed.
    always_comb begin
        accNext = bReg[0] ? acc + aSh : acc;
    end

    // Double-dabble step: add 3 to nibbles >= 5, then shift the next bit in.
    always_comb begin
        bcdAdj = bcdReg;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcdReg[BCD_W*i +: BCD_W] >= 4'd5)
                bcdAdj[BCD_W*i +: BCD_W] = bcdReg[BCD_W*i +: BCD_W] + 4'd3;
        end
        bcdNext = (bcdAdj << 1) | BW'(prodSh[PW-1]);
    end

    for (genvar i = 0; i < DIGITS; i++) begin : gDig
        seg7_decoder uDec (
            .bcd (bcdNext[BCD_W*i +: BCD_W]),
            .seg (segRaw[7*i +: 7])
        );
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank zero digits above the most significant nonzero one.
    always_comb begin
        logic lead;
        lead    = 1'b1;
        segNext = segRaw;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && bcdNext[BCD_W*i +: BCD_W] == 4'd0)
                segNext[7*i +: 7] = SEG_BLANK;
            else
                lead = 1'b0;
        end
    end
`else
    // Every digit shows its value, leading zeros included.
    always_comb begin
        segNext = segRaw;
    end
`endif

    // Sequencer, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bReg    <= '0;
            aSh     <= '0;
            acc     <= '0;
            prodSh  <= '0;
            bcdReg  <= '0;
            product <= '0;
            segOut  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        aSh    <= PW'(a);
                        bReg   <= b;
                        acc    <= '0;
                        bcdReg <= '0;
                        cnt    <= '0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    acc  <= accNext;
                    aSh  <= aSh << 1;
                    bReg <= bReg >> 1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt    <= '0;
                        prodSh <= accNext;
                        state  <= BCD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BCD: begin
                    bcdReg <= bcdNext;
                    prodSh <= prodSh << 1;
                    if (cnt == CW'(PW - 1)) begin
                        product <= acc;
                        segOut  <= segNext;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_bcd_display.sv
// Randomised scoreboard bench for seq_mul_bcd_display (WIDTH=4, DIGITS=3).
// Expected results come from plain arithmetic on the accepted operands.
module tb_seq_mul_bcd_display;

    logic        clk;
    logic        rst;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  product;
    logic [20:0] segOut;

    seq_mul_bcd_display #(.WIDTH(4), .DIGITS(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .product (product),
        .segOut  (segOut)
    );

    typedef struct {
        int          e;
        logic [7:0]  p;
        logic [20:0] s;
    } exp_t;

    exp_t q[$];

    int errors = 0;
    int checks = 0;
    int edgeN  = 0;
    int accEdge = -1000;
    int rstEdge = -1000;

    logic [6:0] segTab [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    logic [7:0]  heldP = '0;
    logic [20:0] heldS = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeN = edgeN + 1;

    function automatic logic [20:0] expSeg(input int v);
        logic [20:0] r;
        int d [3];
        bit lead;
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = (v / 100) % 10;
        r = '0;
        for (int i = 0; i < 3; i++) r[7*i +: 7] = segTab[d[i]];
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = 2; i >= 1; i--) begin
            if (lead && d[i] == 0) r[7*i +: 7] = 7'b0;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at edge %0d",
                     name, act, exp, edgeN);
        end
    endtask

    // Drive one cycle and update the reference model for the next edge.
    task automatic drive(input logic s, input logic [3:0] av,
                         input logic [3:0] bv, input logic r);
        int nextE;
        bit free;
        exp_t x;
        nextE = edgeN + 1;
        rst   = r;
        start = s;
        a     = av;
        b     = bv;
        if (r) begin
            rstEdge = nextE;
            if (q.size() > 0 && q[$].e >= nextE) q.pop_back();
        end else begin
            free = (nextE >= accEdge + 14) ||
                   (rstEdge > accEdge && nextE > rstEdge);
            if (s && free) begin
                accEdge = nextE;
                x.e = nextE + 12;
                x.p = 8'(int'(av) * int'(bv));
                x.s = expSeg(int'(av) * int'(bv));
                q.push_back(x);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare outputs against the model every cycle.
    always @(negedge clk) begin
        int k;
        logic expBusy;
        logic expDone;
        if (edgeN >= 1) begin
            k = edgeN;
            if (rstEdge == k) begin
                heldP = '0;
                heldS = '0;
                expBusy = 1'b0;
                expDone = 1'b0;
            end else begin
                expBusy = (k >= accEdge) && (k <= accEdge + 12) &&
                          !(rstEdge > accEdge && k >= rstEdge);
                expDone = (q.size() > 0) && (q[0].e == k);
            end
            chk("busy", 32'(busy), 32'(expBusy));
            chk("done", 32'(done), 32'(expDone));
            if (expDone) begin
                heldP = q[0].p;
                heldS = q[0].s;
                void'(q.pop_front());
            end
            chk("product", 32'(product), 32'(heldP));
            chk("segOut", 32'(segOut), 32'(heldS));
        end
    end

    initial begin
        repeat (3) drive(1'b1, 4'd15, 4'd15, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 1'b0);

        // 15*15 = 225
        drive(1'b1, 4'd15, 4'd15, 1'b0);
        repeat (16) drive(1'b0, 4'd1, 4'd2, 1'b0);

        // zero operand
        drive(1'b1, 4'd0, 4'd9, 1'b0);
        repeat (16) drive(1'b0, 4'd0, 4'd0, 1'b0);

        // start pulses while busy and during done are ignored
        drive(1'b1, 4'd3, 4'd4, 1'b0);
        for (int c = 1; c <= 16; c++)
            drive(c == 2 || c == 12 || c == 13, 4'd15, 4'd15, 1'b0);

        // reset in flight discards the operation
        drive(1'b1, 4'd7, 4'd7, 1'b0);
        repeat (4) drive(1'b0, 4'd7, 4'd7, 1'b0);
        drive(1'b1, 4'd7, 4'd7, 1'b1);
        repeat (16) drive(1'b0, 4'd7, 4'd7, 1'b0);

        // start held high with operands changing every cycle
        for (int c = 0; c < 60; c++)
            drive(1'b1, 4'($urandom), 4'($urandom), 1'b0);

        // random starts with occasional resets
        for (int c = 0; c < 400; c++)
            drive($urandom_range(0, 2) == 0, 4'($urandom), 4'($urandom),
                  $urandom_range(0, 99) == 0);

        repeat (20) drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
